// File: rtl/dataflow_rx.sv
// dataflow_rx: UART-style serial receiver. It consumes the idle-high line of the
// upstream Tx stage and deframes it into a parallel word.
//
// Frame: start(0), n data bits LSB first, one parity bit, stop(1).
//
// Parameters
//   n                     data bits per frame
//   parity_type_even_odd  0: even (parity bit = ^data), 1: odd (~^data)
//   CLKS_PER_BIT          clk cycles per serial bit (>= 1)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   Rx             serial line, idle high
//   D              last received data word (holds until the next valid)
//   valid          1-cycle pulse: frame complete, D and flags updated
//   parity_error   parity mismatch in the last frame
//   framing_error  stop bit sampled low in the last frame
//   busy           high whenever the receiver is not idle
//
// Build option
//   RX_SYNC_EN  when defined, Rx passes through a 2-flop synchronizer (reset to
//               1) before the FSM, adding 2 cycles to every latency. Leave it
//               undefined for a same-clock connection to the Tx stage.
module dataflow_rx #(
  parameter int   n                    = 8,
  parameter logic parity_type_even_odd = 1'b0,
  parameter int   CLKS_PER_BIT         = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Rx,
  output logic [n-1:0] D,
  output logic         valid,
  output logic         parity_error,
  output logic         framing_error,
  output logic         busy
);

  localparam int BIT_W  = (n > 1) ? $clog2(n) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF   = CLKS_PER_BIT / 2;

  localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_TICK = BAUD_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(n - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [n-1:0]        shreg;
  logic                par_err_q;
  logic                rx_s;
  logic                tick;

  function automatic logic expected_parity(input logic [n-1:0] data);
    return parity_type_even_odd ? ~^data : ^data;
  endfunction

  // New bit enters at the MSB so that after n shifts the first (LSB) bit sits at bit 0.
  function automatic logic [n-1:0] shift_in(input logic [n-1:0] sr, input logic b);
    logic [n:0] wide;
    wide = {b, sr} >> 1;
    return wide[n-1:0];
  endfunction

  // ---- Stage: line input (optional resynchronisation) ----
`ifdef RX_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], Rx};
    end
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = Rx;
`endif

  // Bit-centre sample point; at CLKS_PER_BIT==1 every cycle is a sample.
  assign tick = (baud_cnt == LAST_TICK);

  // ---- Stage: deframing FSM and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      D             <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            // With one clock per bit the detecting edge already is the start-bit sample.
            state <= (CLKS_PER_BIT > 1) ? START : DATA;
          end
        end
        START: begin
          if (baud_cnt == HALF_TICK) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (tick) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (tick) begin
            baud_cnt      <= '0;
            D             <= shreg;
            parity_error  <= par_err_q;
            framing_error <= ~rx_s;
            valid         <= 1'b1;
            // A low stop bit means the line may be held in break; wait for it to rise.
            state         <= rx_s ? IDLE : BREAK;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        BREAK: begin
          baud_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- Stage: data shift register and parity capture (no reset needed) ----
  always_ff @(posedge clk) begin
    if (state == DATA && tick) begin
      shreg <= shift_in(shreg, rx_s);
    end
    if (state == PARITY && tick) begin
      par_err_q <= (rx_s != expected_parity(shreg));
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dataflow_rx.sv
// Bench for dataflow_rx: one instance at one clock per bit, one at four clocks
// per bit. Frame latency is measured from the edge after which the start bit is
// driven to the edge at which a downstream register captures valid.
module tb_dataflow_rx;

`ifdef RX_SYNC_EN
  localparam int LAT    = 14;
  localparam int SYNC_D = 2;
`else
  localparam int LAT    = 12;
  localparam int SYNC_D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx1, rx4;
  logic [7:0] d1, d4;
  logic       v1, pe1, fe1, b1;
  logic       v4, pe4, fe4, b4;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dataflow_rx #(.n(8), .parity_type_even_odd(1'b0), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .Rx(rx1), .D(d1), .valid(v1),
    .parity_error(pe1), .framing_error(fe1), .busy(b1)
  );

  dataflow_rx #(.n(8), .parity_type_even_odd(1'b0), .CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .Rx(rx4), .D(d4), .valid(v4),
    .parity_error(pe4), .framing_error(fe4), .busy(b4)
  );

  // Every valid pulse seen, with the capture edge and whether valid was already high.
  typedef struct {
    int         cap;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       prev;
  } vrec_t;

  vrec_t q1[$];
  vrec_t q4[$];
  logic  v1_prev = 1'b0;
  logic  v4_prev = 1'b0;

  always @(negedge clk) begin
    if (v1) q1.push_back('{cap: cyc + 1, d: d1, pe: pe1, fe: fe1, prev: v1_prev});
    if (v4) q4.push_back('{cap: cyc + 1, d: d4, pe: pe4, fe: fe4, prev: v4_prev});
    v1_prev <= v1;
    v4_prev <= v4;
  end

  // Reference model of one frame.
  typedef struct {
    int         t0;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t eq[$];

  function automatic exp_t model(input int t0, input logic [7:0] d, input logic pbit,
                                 input logic stop);
    exp_t e;
    logic want;
    want = ($countones(d) % 2) == 1;   // even parity: bit makes total ones even
    e.t0 = t0;
    e.d  = d;
    e.pe = (pbit != want);
    e.fe = !stop;
    return e;
  endfunction

  // Table of directed frames for the one-clock-per-bit receiver.
  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic b, input int ncyc);
    if (sel == 1) rx1 = b;
    else          rx4 = b;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int sel, input int cpb, input logic [7:0] d,
                            input logic pbit, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], cpb);
    drive_bit(sel, pbit, cpb);
    drive_bit(sel, stop, cpb);
  endtask

  task automatic expect_frame(input int sel, input int t0, input logic chk_lat,
                              input logic [7:0] ed, input logic epe, input logic efe,
                              input string nm, output int cap);
    vrec_t r;
    bit    got;
    got = 0;
    cap = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (sel == 1) got = (q1.size() > 0);
      else          got = (q4.size() > 0);
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no valid within 400 cycles, expected D=%0h", nm, ed);
    end else begin
      if (sel == 1) r = q1.pop_front();
      else          r = q4.pop_front();
      cap = r.cap;
      chk({nm, "_D"}, 32'(r.d), 32'(ed));
      chk({nm, "_perr"}, 32'(r.pe), 32'(epe));
      chk({nm, "_ferr"}, 32'(r.fe), 32'(efe));
      chk({nm, "_width"}, 32'(r.prev), 32'h0);
      if (chk_lat) chk({nm, "_latency"}, 32'(r.cap - t0), 32'(LAT));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   t0, t1, cap1, cap2, gap;
    logic [7:0] d;
    logic pbit, stop;
    exp_t e;

    tbl[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};

    // Reset with idle line
    rst_n = 1'b0;
    rx1   = 1'b1;
    rx4   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_D",     32'(d1), 32'h0);
    chk("rst_valid", 32'(v1), 32'h0);
    chk("rst_perr",  32'(pe1), 32'h0);
    chk("rst_ferr",  32'(fe1), 32'h0);
    chk("rst_busy",  32'(b1), 32'h0);
    chk("rst_busy4", 32'(b4), 32'h0);
    rst_n = 1'b1;
    drive_bit(1, 1'b1, 4);

    // Directed frames
    for (int i = 0; i < 8; i++) begin
      send_frame(1, 1, tbl[i].d, tbl[i].pbit, tbl[i].stop, t0);
      drive_bit(1, 1'b1, 2);
      expect_frame(1, t0, 1'b1, tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe,
                   $sformatf("tbl%0d", i), cap1);
    end

    // Mid-frame reset: frame abandoned, outputs cleared, no valid afterwards
    drive_bit(1, 1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bit(1, 1'b1, 1);
    chk("midrst_busy_before", 32'(b1), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_D",    32'(d1), 32'h0);
    chk("midrst_busy", 32'(b1), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_bit(1, 1'b1, 20);
    chk("midrst_no_valid", 32'(q1.size()), 32'h0);
    chk("midrst_idle",     32'(b1), 32'h0);

    // Framing error with the line held low afterwards
    send_frame(1, 1, 8'h0F, 1'b0, 1'b0, t0);
    for (int i = 0; i < 5; i++) begin
      drive_bit(1, 1'b0, 1);
      chk($sformatf("break_busy%0d", i), 32'(b1), 32'h1);
    end
    drive_bit(1, 1'b1, 1 + SYNC_D);
    chk("break_release_busy", 32'(b1), 32'h0);
    drive_bit(1, 1'b1, 15);
    expect_frame(1, t0, 1'b1, 8'h0F, 1'b0, 1'b1, "break", cap1);
    chk("break_no_false_start", 32'(q1.size()), 32'h0);

    // Back-to-back zero-gap frames
    send_frame(1, 1, 8'h55, 1'b0, 1'b1, t0);
    send_frame(1, 1, 8'h3C, 1'b0, 1'b1, t1);
    drive_bit(1, 1'b1, 2);
    expect_frame(1, t0, 1'b1, 8'h55, 1'b0, 1'b0, "b2b_first", cap1);
    expect_frame(1, t1, 1'b1, 8'h3C, 1'b0, 1'b0, "b2b_second", cap2);
    chk("b2b_spacing", 32'(cap2 - cap1), 32'd11);

    // Randomized frames, one clock per bit
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      pbit = ($countones(d) % 2 == 1) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? $urandom_range(0, 3) : $urandom_range(1, 3);
      send_frame(1, 1, d, pbit, stop, t0);
      eq.push_back(model(t0, d, pbit, stop));
      drive_bit(1, 1'b1, gap);
    end
    drive_bit(1, 1'b1, 4);
    while (eq.size() > 0) begin
      e = eq.pop_front();
      expect_frame(1, e.t0, 1'b1, e.d, e.pe, e.fe, "rand1", cap1);
    end
    chk("rand1_no_extra", 32'(q1.size()), 32'h0);

    // Four clocks per bit: single-cycle glitch is rejected
    drive_bit(4, 1'b0, 1);
    drive_bit(4, 1'b1, SYNC_D);
    chk("glitch_busy", 32'(b4), 32'h1);
    drive_bit(4, 1'b1, 12);
    chk("glitch_idle",     32'(b4), 32'h0);
    chk("glitch_no_valid", 32'(q4.size()), 32'h0);

    send_frame(4, 4, 8'h81, 1'b0, 1'b1, t0);
    drive_bit(4, 1'b1, 4);
    expect_frame(4, t0, 1'b0, 8'h81, 1'b0, 1'b0, "cpb4_81", cap1);

    // Randomized frames, four clocks per bit
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      pbit = ($countones(d) % 2 == 1) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? $urandom_range(0, 6) : $urandom_range(1, 6);
      send_frame(4, 4, d, pbit, stop, t0);
      eq.push_back(model(t0, d, pbit, stop));
      drive_bit(4, 1'b1, gap);
    end
    drive_bit(4, 1'b1, 8);
    while (eq.size() > 0) begin
      e = eq.pop_front();
      expect_frame(4, e.t0, 1'b0, e.d, e.pe, e.fe, "rand4", cap1);
    end
    chk("rand4_no_extra", 32'(q4.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
